exu_muldiv_iter: RTL and testbench

//  Iterative RV32M multiply/divide unit, directly downstream of the EXU dispatch stage.
//  - Consumes the muldiv request, operands and one-hot op flags, plus the rd tag.
//  - Computes MUL/MULH/MULHSU/MULHU as one registered product.
//  - Computes DIV/DIVU/REM/REMU with a radix-2 restoring divider.
//  - Holds the result under a valid/ready handshake towards the writeback arbiter.

---
 rtl/exu_muldiv_iter.sv | 201 ++++++++++++++++++++
 tb/tb_exu_muldiv_iter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit sitting behind EXU dispatch.
// Multiplies finish in one registered product cycle; divides use a
// 32-step radix-2 restoring divider followed by a sign-fix cycle.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a new request, outputs hold the last result
// MUL    | product of the latched operands is formed and registered
// DIV    | one restoring-divider iteration per cycle, counter 0..31
// FIX    | quotient/remainder sign correction, result registered
// DONE   | result_valid_o high, waiting for result_ready_i
module exu_muldiv_iter #(
   parameter int REG_ADDR_W = 5,
   parameter int DIV_CYCLES = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_muldiv_i,
   output logic                  muldiv_ready_o,
   input  logic [31:0]           op1_i,
   input  logic [31:0]           op2_i,
   input  logic                  op_mul_i,
   input  logic                  op_mulh_i,
   input  logic                  op_mulhsu_i,
   input  logic                  op_mulhu_i,
   input  logic                  op_div_i,
   input  logic                  op_divu_i,
   input  logic                  op_rem_i,
   input  logic                  op_remu_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic                  flush_i,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [31:0]           result_o,
   output logic [REG_ADDR_W-1:0] rd_addr_o,
   output logic                  busy_o
);

   localparam int CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t state, state_nxt;

   // latched operation
   logic [31:0]           op1_q, op2_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  mul_hi_q, mul_sa_q, mul_sb_q;
   logic                  rem_sel_q, neg_q_q, neg_r_q;

   // divider registers
   logic [31:0]      quo, rem_r, dvs;
   logic [CNT_W-1:0] cnt;

   // request decode
   logic        is_mul_req, is_div_req, sgn_req, rem_req;
   logic        div_zero, div_ovf, fast_path, accept;
   logic [31:0] fast_res, abs1, abs2;

   // datapath comb
   logic signed [32:0] mul_a33, mul_b33;
   logic signed [63:0] mul_a64, mul_b64, prod;
   logic [31:0]        mul_res;
   logic [32:0]        rem_sh, diff;
   logic               ge;
   logic [31:0]        q_fix, r_fix, fix_res;

   // request decode and fast-path detection
   always_comb begin
      is_mul_req = op_mul_i | op_mulh_i | op_mulhsu_i | op_mulhu_i;
      is_div_req = op_div_i | op_divu_i | op_rem_i | op_remu_i;
      sgn_req    = op_div_i | op_rem_i;
      rem_req    = op_rem_i | op_remu_i;
      div_zero   = (op2_i == 32'h0);
      div_ovf    = sgn_req & (op1_i == 32'h8000_0000) & (op2_i == 32'hFFFF_FFFF);
      fast_path  = div_zero | div_ovf;
      accept     = req_muldiv_i & muldiv_ready_o & ~flush_i;
      abs1       = (sgn_req & op1_i[31]) ? -op1_i : op1_i;
      abs2       = (sgn_req & op2_i[31]) ? -op2_i : op2_i;
      if (div_zero) fast_res = rem_req ? op1_i : 32'hFFFF_FFFF;
      else          fast_res = rem_req ? 32'h0 : 32'h8000_0000;
   end

   // product: low 64 bits of the signed product of the 33-bit extended operands
   always_comb begin
      mul_a33 = {mul_sa_q & op1_q[31], op1_q};
      mul_b33 = {mul_sb_q & op2_q[31], op2_q};
      mul_a64 = {{31{mul_a33[32]}}, mul_a33};
      mul_b64 = {{31{mul_b33[32]}}, mul_b33};
      prod    = mul_a64 * mul_b64;
      mul_res = mul_hi_q ? prod[63:32] : prod[31:0];
   end

   // one restoring step plus the final sign correction
   always_comb begin
      rem_sh  = {rem_r, quo[31]};
      diff    = rem_sh - {1'b0, dvs};
      ge      = ~diff[32];
      q_fix   = neg_q_q ? -quo : quo;
      r_fix   = neg_r_q ? -rem_r : rem_r;
      fix_res = rem_sel_q ? r_fix : q_fix;
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // next-state logic; flush overrides every transition
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_mul_req)      state_nxt = S_MUL;
               else if (is_div_req) state_nxt = fast_path ? S_DONE : S_DIV;
               else                 state_nxt = S_IDLE;
            end
         end
         S_MUL:  state_nxt = S_DONE;
         S_DIV:  if (cnt == CNT_LAST) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: if (result_ready_i) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush_i) state_nxt = S_IDLE;
   end

   // status outputs decoded from state; flush masks valid so no handshake can complete
   always_comb begin
      muldiv_ready_o = (state == S_IDLE);
      busy_o         = (state != S_IDLE);
      result_valid_o = (state == S_DONE) & ~flush_i;
   end

   // operand latch, divider iteration and registered result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op1_q     <= '0;
         op2_q     <= '0;
         rd_q      <= '0;
         mul_hi_q  <= 1'b0;
         mul_sa_q  <= 1'b0;
         mul_sb_q  <= 1'b0;
         rem_sel_q <= 1'b0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         quo       <= '0;
         rem_r     <= '0;
         dvs       <= '0;
         cnt       <= '0;
         result_o  <= '0;
         rd_addr_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op1_q     <= op1_i;
                  op2_q     <= op2_i;
                  rd_q      <= rd_addr_i;
                  mul_hi_q  <= op_mulh_i | op_mulhsu_i | op_mulhu_i;
                  mul_sa_q  <= op_mulh_i | op_mulhsu_i;
                  mul_sb_q  <= op_mulh_i;
                  rem_sel_q <= rem_req;
                  neg_q_q   <= sgn_req & (op1_i[31] ^ op2_i[31]);
                  neg_r_q   <= sgn_req & op1_i[31];
                  quo       <= abs1;
                  rem_r     <= '0;
                  dvs       <= abs2;
                  cnt       <= '0;
                  if (!is_mul_req && is_div_req && fast_path) begin
                     result_o  <= fast_res;
                     rd_addr_o <= rd_addr_i;
                  end
               end
            end
            S_MUL: begin
               if (!flush_i) begin
                  result_o  <= mul_res;
                  rd_addr_o <= rd_q;
               end
            end
            S_DIV: begin
               rem_r <= ge ? diff[31:0] : rem_sh[31:0];
               quo   <= {quo[30:0], ge};
               cnt   <= cnt + CNT_W'(1);
            end
            S_FIX: begin
               if (!flush_i) begin
                  result_o  <= fix_res;
                  rd_addr_o <= rd_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_exu_muldiv_iter.sv
// Scoreboard bench for exu_muldiv_iter: the driver pushes hand-computed
// results, the monitor pops and compares on every result handshake.
// Latency is counted from the driving negedge to the first negedge valid is seen.
module tb_exu_muldiv_iter;

   localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
   localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_muldiv_i = 1'b0;
   logic        muldiv_ready_o;
   logic [31:0] op1_i = '0, op2_i = '0;
   logic [7:0]  op_sel = '0;
   logic [4:0]  rd_addr_i = '0;
   logic        flush_i = 1'b0;
   logic        result_valid_o;
   logic        result_ready_i = 1'b1;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;
   logic        busy_o;

   exu_muldiv_iter #(.REG_ADDR_W(5), .DIV_CYCLES(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_muldiv_i   (req_muldiv_i),
      .muldiv_ready_o (muldiv_ready_o),
      .op1_i          (op1_i),
      .op2_i          (op2_i),
      .op_mul_i       (op_sel[0]),
      .op_mulh_i      (op_sel[1]),
      .op_mulhsu_i    (op_sel[2]),
      .op_mulhu_i     (op_sel[3]),
      .op_div_i       (op_sel[4]),
      .op_divu_i      (op_sel[5]),
      .op_rem_i       (op_sel[6]),
      .op_remu_i      (op_sel[7]),
      .rd_addr_i      (rd_addr_i),
      .flush_i        (flush_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_o       (result_o),
      .rd_addr_o      (rd_addr_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          t0;
      int          lat;
      int          id;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   next_id = 0;
   bit   seen_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // monitor: latency on first valid, data/tag on handshake, no result without an entry
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && result_valid_o) begin
            if (sb_q.size() == 0) begin
               chk("spurious_valid", {31'b0, result_valid_o}, 32'h0);
            end else begin
               if (!seen_valid) begin
                  seen_valid = 1'b1;
                  if (sb_q[0].lat >= 0)
                     chk($sformatf("latency#%0d", sb_q[0].id), 32'(cyc - sb_q[0].t0), 32'(sb_q[0].lat));
               end
               if (result_ready_i) begin
                  e = sb_q.pop_front();
                  seen_valid = 1'b0;
                  chk($sformatf("result#%0d", e.id), result_o, e.res);
                  chk($sformatf("rd#%0d", e.id), {27'b0, rd_addr_o}, {27'b0, e.rd});
               end
            end
         end
      end
   end

   task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input bit push);
      @(negedge clk);
      chk($sformatf("ready_at_issue#%0d", next_id), {31'b0, muldiv_ready_o}, 32'h1);
      op_sel       = 8'h0;
      op_sel[op]   = 1'b1;
      op1_i        = a;
      op2_i        = b;
      rd_addr_i    = rd;
      req_muldiv_i = 1'b1;
      if (push) sb_q.push_back('{exp, rd, cyc, lat, next_id});
      next_id++;
      @(negedge clk);
      req_muldiv_i = 1'b0;
      op_sel       = 8'h0;
   endtask

   task automatic wait_idle(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && muldiv_ready_o) done = 1'b1;
      end
      if (!done) begin
         n_checks++;
         $display("FAIL timeout: %0d results outstanding, expected 0", sb_q.size());
         sb_q.delete();
         seen_valid = 1'b0;
      end
   endtask

   task automatic wait_valid(input int budget, input string name);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (result_valid_o) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         $display("FAIL %s: valid never rose within %0d cycles", name, budget);
      end
   endtask

   typedef struct {
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      // multiplies: product cycle then DONE
      vecs.push_back('{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2});
      vecs.push_back('{OP_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 2});
      vecs.push_back('{OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'h8000_0000, 2});
      vecs.push_back('{OP_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h7FFF_FFFF, 2});
      vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 2});
      vecs.push_back('{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0000_0001, 2});
      // divides: 32 iterations, fix cycle, DONE
      vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd13, 32'hFFFF_FFFD, 34});
      vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd14, 32'hFFFF_FFFF, 34});
      vecs.push_back('{OP_DIVU,   32'd100,       32'd7,         5'd15, 32'd14,        34});
      vecs.push_back('{OP_REMU,   32'd100,       32'd7,         5'd16, 32'd2,         34});
      vecs.push_back('{OP_DIV,    32'd7,         32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, 34});
      vecs.push_back('{OP_REM,    32'd7,         32'hFFFF_FFFE, 5'd18, 32'd1,         34});
      vecs.push_back('{OP_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd19, 32'hFFFF_FFFF, 34});
      vecs.push_back('{OP_REMU,   32'hFFFF_FFFF, 32'h10,        5'd20, 32'h0000_000F, 34});
      vecs.push_back('{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h0000_0000, 34});
      // fast path: straight to DONE
      vecs.push_back('{OP_DIVU,   32'd5,         32'd0,         5'd22, 32'hFFFF_FFFF, 1});
      vecs.push_back('{OP_REM,    32'd5,         32'd0,         5'd23, 32'd5,         1});
      vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'h8000_0000, 1});
      vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 32'h0000_0000, 1});

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'b0, result_valid_o}, 32'h0);
      chk("rst_result", result_o, 32'h0);
      chk("rst_rd", {27'b0, rd_addr_o}, 32'h0);
      chk("rst_busy", {31'b0, busy_o}, 32'h0);
      chk("rst_ready", {31'b0, muldiv_ready_o}, 32'h1);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, 1'b1);
         if (i == 0) begin
            chk("busy_in_mul", {31'b0, busy_o}, 32'h1);
            chk("ready_in_mul", {31'b0, muldiv_ready_o}, 32'h0);
         end
         wait_idle(60);
      end

      // backpressure: DONE holds everything stable for 10 cycles
      result_ready_i = 1'b0;
      issue(OP_MUL, 32'd6, 32'd7, 5'd9, 32'd42, -1, 1'b1);
      wait_valid(10, "bp_valid_rise");
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bp_valid_%0d", i), {31'b0, result_valid_o}, 32'h1);
         chk($sformatf("bp_result_%0d", i), result_o, 32'd42);
         chk($sformatf("bp_rd_%0d", i), {27'b0, rd_addr_o}, 32'd9);
         chk($sformatf("bp_ready_%0d", i), {31'b0, muldiv_ready_o}, 32'h0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 result_ready_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_single_transfer", {31'b0, result_valid_o}, 32'h0);
      chk("bp_queue_drained", 32'(sb_q.size()), 32'h0);
      chk("bp_back_idle", {31'b0, muldiv_ready_o}, 32'h1);

      // flush in DONE beats result_ready_i
      result_ready_i = 1'b0;
      issue(OP_MUL, 32'd3, 32'd3, 5'd4, 32'd9, -1, 1'b1);
      wait_valid(10, "fdone_valid_rise");
      @(posedge clk);
      #1 flush_i = 1'b1;
      result_ready_i = 1'b1;
      @(negedge clk);
      chk("fdone_valid_masked", {31'b0, result_valid_o}, 32'h0);
      @(posedge clk);
      #1 flush_i = 1'b0;
      sb_q.delete();
      seen_valid = 1'b0;
      @(negedge clk);
      chk("fdone_idle", {31'b0, busy_o}, 32'h0);
      repeat (3) @(negedge clk);

      // flush with a request in IDLE drops it
      op_sel = 8'h1; op1_i = 32'd2; op2_i = 32'd2; rd_addr_i = 5'd2;
      req_muldiv_i = 1'b1;
      flush_i = 1'b1;
      @(negedge clk);
      req_muldiv_i = 1'b0;
      flush_i = 1'b0;
      op_sel = 8'h0;
      chk("fidle_dropped", {31'b0, busy_o}, 32'h0);
      repeat (4) @(negedge clk);

      // flush at divider iteration 17
      issue(OP_DIVU, 32'd100, 32'd7, 5'd6, 32'd14, -1, 1'b0);
      repeat (17) @(negedge clk);
      chk("fdiv_busy_before", {31'b0, busy_o}, 32'h1);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("fdiv_busy", {31'b0, busy_o}, 32'h0);
      chk("fdiv_ready", {31'b0, muldiv_ready_o}, 32'h1);
      chk("fdiv_valid", {31'b0, result_valid_o}, 32'h0);
      repeat (40) @(negedge clk);
      issue(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd26, 32'hFFFF_FFEB, 2, 1'b1);
      wait_idle(20);

      // reset pulse mid-divide aborts asynchronously
      issue(OP_DIVU, 32'd100, 32'd7, 5'd8, 32'd14, -1, 1'b0);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_result", result_o, 32'h0);
      chk("arst_rd", {27'b0, rd_addr_o}, 32'h0);
      chk("arst_busy", {31'b0, busy_o}, 32'h0);
      chk("arst_ready", {31'b0, muldiv_ready_o}, 32'h1);
      chk("arst_valid", {31'b0, result_valid_o}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      issue(OP_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd27, 32'h7FFF_FFFF, 2, 1'b1);
      wait_idle(20);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
